// File: rtl/led_frame_scheduler_if.sv
// led_frame_scheduler_if: color handoff from the frame scheduler to the serial LED driver.
interface led_frame_scheduler_if #(
    parameter int FBUF_COLOR_WIDTH = 24
);
    logic [FBUF_COLOR_WIDTH-1:0] color_out;
    logic                        color_out_valid;
    logic                        color_out_ready;
    modport master(output color_out, color_out_valid, input color_out_ready);
    modport slave(input color_out, color_out_valid, output color_out_ready);
endinterface

// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: walks the LED color buffer one address per slot, hands each settled
// color to the strip driver, then holds the strip latch gap before the next frame.
module led_frame_scheduler #(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = $clog2(NUM_LEDS),
    parameter int FBUF_COLOR_WIDTH  = 24,
    parameter int SETTLE_CYCLES     = 3,
    parameter int LATCH_CYCLES      = 6000
) (
    input  logic                         clk_led,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         color_valid,
    input  logic [FBUF_COLOR_WIDTH-1:0]  color_in,
    output logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address,
    led_frame_scheduler_if.master        drv,
    output logic                         latch_active,
    output logic                         frame_done,
    output logic                         busy
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES);
    localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
    localparam logic [LED_ADDRESS_WIDTH-1:0] ADDR_LAST = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, LATCH} state_t;

    state_t                        state, state_n;
    logic [LED_ADDRESS_WIDTH-1:0]  addr, addr_n;
    logic [FBUF_COLOR_WIDTH-1:0]   color_q, color_n;
    logic                          valid_q, valid_n;
    logic [SW-1:0]                 settle, settle_n;
    logic [LW-1:0]                 latch_cnt, latch_n;

    assign next_led_request_address = addr;
    assign drv.color_out            = color_q;
    assign drv.color_out_valid      = valid_q;

    always_ff @(posedge clk_led or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= '0;
            color_q      <= '0;
            valid_q      <= 1'b0;
            settle       <= '0;
            latch_cnt    <= '0;
            busy         <= 1'b0;
            latch_active <= 1'b0;
        end else begin
            state        <= state_n;
            addr         <= addr_n;
            color_q      <= color_n;
            valid_q      <= valid_n;
            settle       <= settle_n;
            latch_cnt    <= latch_n;
            busy         <= state_n != IDLE;
            latch_active <= state_n == LATCH;
        end
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        color_n    = color_q;
        valid_n    = valid_q;
        settle_n   = settle;
        latch_n    = latch_cnt;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                addr_n = '0;
                if (enable) begin
                    state_n  = FETCH;
                    settle_n = '0;
                end
            end
            FETCH: begin
                // Buffer read data is untrusted until the address has been stable long enough.
                if (settle != SETTLE_LAST) settle_n = settle + SW'(1);
                else if (color_valid) begin
                    color_n = color_in;
                    valid_n = 1'b1;
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                if (drv.color_out_ready) begin
                    valid_n  = 1'b0;
                    state_n  = addr == ADDR_LAST ? LATCH : FETCH;
                    addr_n   = addr == ADDR_LAST ? '0 : addr + LED_ADDRESS_WIDTH'(1);
                    settle_n = '0;
                    latch_n  = '0;
                end
            end
            LATCH: begin
                addr_n  = '0;
                latch_n = latch_cnt + LW'(1);
                if (latch_cnt == LATCH_LAST) begin
                    frame_done = 1'b1;
                    state_n    = enable ? FETCH : IDLE;
                    settle_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler: directed scenarios on a 4-LED strip with a 10-cycle latch gap.
module tb_led_frame_scheduler;
    localparam int W = 24;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         color_valid = 1'b0;
    logic [W-1:0] color_in;
    logic [1:0]   addr;
    logic         latch_active, frame_done, busy;
    int           checks = 0;
    int           failures = 0;

    led_frame_scheduler_if #(.FBUF_COLOR_WIDTH(W)) drv();

    led_frame_scheduler #(
        .NUM_LEDS(4), .FBUF_COLOR_WIDTH(W), .SETTLE_CYCLES(3), .LATCH_CYCLES(10)
    ) dut (
        .clk_led(clk), .rst(rst), .enable(enable), .color_valid(color_valid),
        .color_in(color_in), .next_led_request_address(addr), .drv(drv),
        .latch_active(latch_active), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;
    // Buffer model: color = 0x000100 * address
    assign color_in = {14'd0, addr, 8'd0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        enable = 0;
        color_valid = 0;
        drv.color_out_ready = 0;
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        drv.color_out_ready = 0;
        step();
        checks++;
        if ({addr, drv.color_out, drv.color_out_valid, latch_active, frame_done, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got addr=%0d color=%h valid=%b latch=%b done=%b busy=%b exp all 0",
                     addr, drv.color_out, drv.color_out_valid, latch_active, frame_done, busy);
        end
        rst = 0;
    endtask

    task automatic test_basic_frame();
        int tc[$];
        logic [W-1:0] tcol[$];
        int c = 0, latch_n = 0, done_n = 0, first2 = -1;
        reset_dut();
        enable = 1; color_valid = 1; drv.color_out_ready = 1;
        while (done_n == 0 && c < 200) begin
            step(); c++;
            if (drv.color_out_valid && drv.color_out_ready) begin
                tc.push_back(c);
                tcol.push_back(drv.color_out);
            end
            if (latch_active) latch_n++;
            if (frame_done) done_n++;
        end
        checks++;
        if (done_n != 1 || tc.size() != 4) begin
            failures++;
            $display("FAIL basic_frame_count got done=%0d xfers=%0d exp done=1 xfers=4", done_n, tc.size());
        end
        for (int i = 0; i < tc.size() && i < 4; i++) begin
            checks++;
            if (tcol[i] !== W'(i * 'h100) || tc[i] != 5 + 5 * i) begin
                failures++;
                $display("FAIL basic_xfer%0d got color=%h cycle=%0d exp color=%h cycle=%0d",
                         i, tcol[i], tc[i], W'(i * 'h100), 5 + 5 * i);
            end
        end
        checks++;
        if (latch_n != 10) begin
            failures++;
            $display("FAIL basic_latch_len got=%0d exp=10", latch_n);
        end
        step(); c++;
        checks++;
        if (latch_active !== 0 || addr !== 0 || busy !== 1 || frame_done !== 0) begin
            failures++;
            $display("FAIL basic_after_latch got latch=%b addr=%0d busy=%b done=%b exp 0 0 1 0",
                     latch_active, addr, busy, frame_done);
        end
        for (int i = 0; i < 10 && first2 < 0; i++) begin
            step(); c++;
            if (drv.color_out_valid) first2 = c;
        end
        checks++;
        if (first2 != 35 || drv.color_out !== 24'h0 || addr !== 0) begin
            failures++;
            $display("FAIL basic_next_frame got cycle=%0d color=%h addr=%0d exp cycle=35 color=0 addr=0",
                     first2, drv.color_out, addr);
        end
    endtask

    task automatic test_backpressure();
        int c = 0, xfers = 0;
        reset_dut();
        enable = 1; color_valid = 1; drv.color_out_ready = 1;
        while (!(drv.color_out_valid && addr == 2) && c < 100) begin
            step(); c++;
        end
        drv.color_out_ready = 0;
        checks++;
        if (c >= 100) begin
            failures++;
            $display("FAIL bp_reach_addr2 got timeout exp valid at addr 2");
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (addr !== 2 || drv.color_out !== 24'h000200 || drv.color_out_valid !== 1) begin
                failures++;
                $display("FAIL bp_stable%0d got addr=%0d color=%h valid=%b exp 2 000200 1",
                         i, addr, drv.color_out, drv.color_out_valid);
            end
        end
        drv.color_out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (drv.color_out_valid && drv.color_out_ready && drv.color_out == 24'h000200) xfers++;
            step();
        end
        checks++;
        if (xfers != 1) begin
            failures++;
            $display("FAIL bp_single_xfer got=%0d exp=1", xfers);
        end
    endtask

    task automatic test_settle();
        int c = 0, chg = 0;
        logic [1:0] pa;
        logic pv;
        reset_dut();
        enable = 1; color_valid = 1; drv.color_out_ready = 1;
        pa = addr; pv = 0;
        for (int i = 0; i < 20; i++) begin
            step(); c++;
            if (addr != pa) chg = c;
            if (drv.color_out_valid && !pv && addr != 0) begin
                checks++;
                if (c - chg != 4) begin
                    failures++;
                    $display("FAIL settle_gap_addr%0d got=%0d exp=4", addr, c - chg);
                end
            end
            pa = addr; pv = drv.color_out_valid;
        end
        reset_dut();
        enable = 1; color_valid = 1; drv.color_out_ready = 1;
        c = 0;
        while (addr != 1 && c < 50) begin
            step(); c++;
        end
        color_valid = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            checks++;
            if (drv.color_out_valid !== 0) begin
                failures++;
                $display("FAIL settle_wait%0d got valid=%b exp 0", k, drv.color_out_valid);
            end
        end
        color_valid = 1;
        step();
        checks++;
        if (drv.color_out_valid !== 1 || drv.color_out !== 24'h000100) begin
            failures++;
            $display("FAIL settle_capture got valid=%b color=%h exp 1 000100", drv.color_out_valid, drv.color_out);
        end
    endtask

    task automatic test_enable_drop();
        int c = 0, xfers = 0, done_n = 0;
        logic [W-1:0] last = '0;
        reset_dut();
        enable = 1; color_valid = 1; drv.color_out_ready = 1;
        while (addr != 1 && c < 50) begin
            step(); c++;
        end
        enable = 0;
        c = 0;
        while (done_n == 0 && c < 100) begin
            if (drv.color_out_valid && drv.color_out_ready) begin
                xfers++;
                last = drv.color_out;
            end
            step(); c++;
            if (frame_done) done_n++;
        end
        checks++;
        if (done_n != 1 || xfers != 3 || last !== 24'h000300) begin
            failures++;
            $display("FAIL drop_complete got done=%0d xfers=%0d last=%h exp 1 3 000300", done_n, xfers, last);
        end
        step();
        checks++;
        if (busy !== 0 || addr !== 0 || latch_active !== 0) begin
            failures++;
            $display("FAIL drop_idle got busy=%b addr=%0d latch=%b exp 0 0 0", busy, addr, latch_active);
        end
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (busy !== 0 || drv.color_out_valid !== 0) begin
            failures++;
            $display("FAIL drop_stays_idle got busy=%b valid=%b exp 0 0", busy, drv.color_out_valid);
        end
    endtask

    task automatic test_async_reset();
        int c = 0, done_n = 0, first = -1;
        logic [W-1:0] fcol = '1;
        logic [1:0] faddr = '1;
        reset_dut();
        enable = 1; color_valid = 1; drv.color_out_ready = 1;
        while (!(drv.color_out_valid && addr == 2) && c < 100) begin
            step(); c++;
        end
        drv.color_out_ready = 0;
        #2;
        rst = 1;
        #1;
        checks++;
        if ({addr, drv.color_out, drv.color_out_valid, latch_active, frame_done, busy} !== '0) begin
            failures++;
            $display("FAIL async_reset got addr=%0d color=%h valid=%b latch=%b done=%b busy=%b exp all 0",
                     addr, drv.color_out, drv.color_out_valid, latch_active, frame_done, busy);
        end
        @(negedge clk);
        rst = 0;
        drv.color_out_ready = 1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (frame_done) done_n++;
            if (drv.color_out_valid && first < 0) begin
                first = i;
                fcol = drv.color_out;
                faddr = addr;
            end
        end
        checks++;
        if (first < 0 || fcol !== 24'h0 || faddr !== 0 || done_n != 0) begin
            failures++;
            $display("FAIL async_restart got first=%0d color=%h addr=%0d done=%0d exp color=0 addr=0 done=0",
                     first, fcol, faddr, done_n);
        end
    endtask

    task automatic test_idle();
        reset_dut();
        color_valid = 1;
        for (int i = 0; i < 100; i++) begin
            drv.color_out_ready = i[0];
            step();
            checks++;
            if ({busy, drv.color_out_valid, addr, frame_done} !== '0) begin
                failures++;
                $display("FAIL idle_hold%0d got busy=%b valid=%b addr=%0d done=%b exp all 0",
                         i, busy, drv.color_out_valid, addr, frame_done);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        drv.color_out_ready = 0;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_settle();
        test_enable_drop();
        test_async_reset();
        test_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
